// File: rtl/pipelined_prefix_adder.sv
// Kogge-Stone adder/subtractor with STAGES pipeline ranks and valid/ready on both sides.
// Define PREFIX_ADDER_SAT_EN to saturate z to the signed limit on overflow.
module pipelined_prefix_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             carry_out,
    output logic             overflow
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int NMID   = STAGES - 1;
    localparam int SPACE  = (STAGES > 1) ? (LEVELS + STAGES - 2) / (STAGES - 1) : LEVELS;

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] p0;
        logic             cin;
    } gp_t;

    typedef struct packed {
        logic             ovf;
        logic             cout;
        logic [WIDTH-1:0] z;
    } res_t;

    // Prefix level after which pipeline rank r sits; surplus ranks collapse onto the last level.
    function automatic int rank_pos(input int r);
        if (r * SPACE > LEVELS) return LEVELS;
        return r * SPACE;
    endfunction

    function automatic gp_t leaf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, input logic s);
        gp_t              r;
        logic [WIDTH-1:0] b_eff;
        b_eff = b ^ {WIDTH{s}};
        r.g   = a & b_eff;
        r.p   = a ^ b_eff;
        r.p0  = a ^ b_eff;
        r.cin = c;
        return r;
    endfunction

    // Applies Kogge-Stone levels lo..hi; level l combines spans at distance 2^(l-1).
    function automatic gp_t prefix(input gp_t b, input int lo, input int hi);
        gp_t              r;
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] g_sh;
        logic [WIDTH-1:0] p_sh;
        int               d;
        r    = b;
        ones = '1;
        for (int lvl = lo; lvl <= hi; lvl++) begin
            d    = 1 << (lvl - 1);
            g_sh = r.g << d;
            p_sh = (r.p << d) | ~(ones << d);
            r.g  = r.g | (r.p & g_sh);
            r.p  = r.p & p_sh;
        end
        return r;
    endfunction

    function automatic res_t finish(input gp_t b);
        res_t           r;
        logic [WIDTH:0] c;
        c      = {b.g | (b.p & {WIDTH{b.cin}}), b.cin};
        r.z    = b.p0 ^ c[WIDTH-1:0];
        r.cout = c[WIDTH];
        r.ovf  = c[WIDTH] ^ c[WIDTH-1];
`ifdef PREFIX_ADDER_SAT_EN
        if (r.ovf) r.z = {r.cout, {(WIDTH-1){~r.cout}}};
`endif
        return r;
    endfunction

    logic             advance;
    gp_t              fin_in;
    logic             fin_vld;
    res_t             fin_res;
    logic             valid_q;
    logic [WIDTH-1:0] z_q;
    logic             carry_q;
    logic             ovf_q;

    assign advance  = ~valid_q | out_ready;
    assign in_ready = advance;

    if (STAGES == 1) begin : g_comb
        assign fin_in  = prefix(leaf(x, y, carry_in, sub), 1, LEVELS);
        assign fin_vld = in_valid;
    end else begin : g_pipe
        gp_t             mid_d [NMID];
        gp_t             mid_q [NMID];
        logic [NMID-1:0] mid_vld_q;

        for (genvar r = 0; r < NMID; r++) begin : g_rank
            if (r == 0) begin : g_leaf
                assign mid_d[r] = leaf(x, y, carry_in, sub);
            end else begin : g_levels
                assign mid_d[r] = prefix(mid_q[r-1], rank_pos(r - 1) + 1, rank_pos(r));
            end
        end

        // NOTE: datapath ranks carry no reset; the valid bits alone say whether they hold a beat.
        always_ff @(posedge clock) begin
            if (advance) begin
                for (int r = 0; r < NMID; r++) mid_q[r] <= mid_d[r];
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                mid_vld_q <= '0;
            end else if (advance) begin
                mid_vld_q[0] <= in_valid;
                for (int r = 1; r < NMID; r++) mid_vld_q[r] <= mid_vld_q[r-1];
            end
        end

        assign fin_in  = prefix(mid_q[NMID-1], rank_pos(NMID - 1) + 1, LEVELS);
        assign fin_vld = mid_vld_q[NMID-1];
    end

    assign fin_res = finish(fin_in);

    // Result flops load only with a real beat, so they hold the last result across bubbles.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            z_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (advance) begin
            valid_q <= fin_vld;
            if (fin_vld) begin
                z_q     <= fin_res.z;
                carry_q <= fin_res.cout;
                ovf_q   <= fin_res.ovf;
            end
        end
    end

    assign out_valid = valid_q;
    assign z         = z_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench for pipelined_prefix_adder: an 8-bit/2-stage and a 13-bit/4-stage instance
// share stimulus and are scored against an arithmetic reference model.
module tb_pipelined_prefix_adder;
    localparam int WA = 8;
    localparam int SA = 2;
    localparam int WB = 13;
    localparam int SB = 4;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          out_ready;
    logic          carry_in;
    logic          sub;
    logic [WB-1:0] xs;
    logic [WB-1:0] ys;

    logic          a_in_ready, a_out_valid, a_cout, a_ovf;
    logic [WA-1:0] a_z;
    logic          b_in_ready, b_out_valid, b_cout, b_ovf;
    logic [WB-1:0] b_z;

    int errors = 0;
    int checks = 0;

    logic [33:0] qa[$];
    logic [33:0] qb[$];

    pipelined_prefix_adder #(.WIDTH(WA), .STAGES(SA)) dut_a (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .x(xs[WA-1:0]), .y(ys[WA-1:0]), .carry_in(carry_in), .sub(sub),
        .out_valid(a_out_valid), .out_ready(out_ready), .z(a_z),
        .carry_out(a_cout), .overflow(a_ovf)
    );

    pipelined_prefix_adder #(.WIDTH(WB), .STAGES(SB)) dut_b (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .x(xs), .y(ys), .carry_in(carry_in), .sub(sub),
        .out_valid(b_out_valid), .out_ready(out_ready), .z(b_z),
        .carry_out(b_cout), .overflow(b_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    // Returns {overflow, carry_out, z} for a w-bit add/subtract, computed with plain integers.
    function automatic logic [33:0] model(input logic [31:0] xa, input logic [31:0] ya,
                                          input logic ci, input logic sb, input int w);
        logic [32:0] mask;
        logic [32:0] s;
        logic [31:0] xm, ym, zm;
        logic        sx, sy, ov;
        mask = (33'd1 << w) - 33'd1;
        xm   = xa & mask[31:0];
        ym   = (sb ? ~ya : ya) & mask[31:0];
        s    = {1'b0, xm} + {1'b0, ym} + {32'd0, ci};
        zm   = s[31:0] & mask[31:0];
        sx   = xm[w-1];
        sy   = ym[w-1];
        ov   = (sx == sy) && (zm[w-1] != sx);
`ifdef PREFIX_ADDER_SAT_EN
        if (ov) zm = sx ? (32'd1 << (w - 1)) : ((32'd1 << (w - 1)) - 32'd1);
`endif
        return {ov, s[w], zm};
    endfunction

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    // Presents one beat and returns in the cycle its result is due on dut_a.
    task automatic send_beat(input logic [WB-1:0] xv, input logic [WB-1:0] yv,
                             input logic ci, input logic sb);
        xs        = xv;
        ys        = yv;
        carry_in  = ci;
        sub       = sb;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (SA - 1) @(negedge clock);
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        xs        = 13'h0FF;
        ys        = 13'h001;
        carry_in  = 1'b1;
        sub       = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({a_out_valid, a_z, a_cout, a_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_state_a: got valid/z/cout/ovf=%b/%h/%b/%b expected 0/00/0/0",
                     a_out_valid, a_z, a_cout, a_ovf);
        end
        checks++;
        if ({b_out_valid, b_z, b_cout, b_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_state_b: got valid/z=%b/%h expected 0/0000", b_out_valid, b_z);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got in_ready/out_valid=%b/%b expected 1/0",
                     a_in_ready, a_out_valid);
        end
    endtask

    task automatic test_add;
        send_beat(13'h0FF, 13'h001, 1'b1, 1'b0);
        checks++;
        if (a_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL add_latency: got out_valid=%b expected 1", a_out_valid);
        end
        checks++;
        if ({a_ovf, a_cout, a_z} !== {1'b0, 1'b1, 8'h01}) begin
            errors++;
            $display("FAIL add_result: got ovf/cout/z=%b/%b/%h expected 0/1/01", a_ovf, a_cout, a_z);
        end
        @(negedge clock);
        checks++;
        if (a_out_valid !== 1'b0 || a_z !== 8'h01 || a_cout !== 1'b1) begin
            errors++;
            $display("FAIL add_hold: got valid/z/cout=%b/%h/%b expected 0/01/1", a_out_valid, a_z, a_cout);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] exp_z;
`ifdef PREFIX_ADDER_SAT_EN
        exp_z = 8'h7F;
`else
        exp_z = 8'h80;
`endif
        send_beat(13'h07F, 13'h001, 1'b0, 1'b0);
        checks++;
        if (a_out_valid !== 1'b1 || {a_ovf, a_cout, a_z} !== {1'b1, 1'b0, exp_z}) begin
            errors++;
            $display("FAIL ovf_add: got valid/ovf/cout/z=%b/%b/%b/%h expected 1/1/0/%h",
                     a_out_valid, a_ovf, a_cout, a_z, exp_z);
        end
    endtask

    task automatic test_sub;
        logic [7:0] exp_z;
`ifdef PREFIX_ADDER_SAT_EN
        exp_z = 8'h80;
`else
        exp_z = 8'h7F;
`endif
        send_beat(13'h010, 13'h020, 1'b1, 1'b1);
        checks++;
        if (a_out_valid !== 1'b1 || {a_ovf, a_cout, a_z} !== {1'b0, 1'b0, 8'hF0}) begin
            errors++;
            $display("FAIL sub_basic: got valid/ovf/cout/z=%b/%b/%b/%h expected 1/0/0/f0",
                     a_out_valid, a_ovf, a_cout, a_z);
        end
        send_beat(13'h080, 13'h001, 1'b1, 1'b1);
        checks++;
        if (a_out_valid !== 1'b1 || {a_ovf, a_cout, a_z} !== {1'b1, 1'b1, exp_z}) begin
            errors++;
            $display("FAIL sub_ovf: got valid/ovf/cout/z=%b/%b/%b/%h expected 1/1/1/%h",
                     a_out_valid, a_ovf, a_cout, a_z, exp_z);
        end
    endtask

    task automatic test_back_to_back;
        int          sent;
        int          got;
        logic [10:0] held;
        logic [33:0] e;
        idle(SB + 2);
        qa.delete();
        sent = 0;
        got  = 0;
        held = '0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            in_valid  = (sent < 6);
            xs        = WB'($urandom);
            ys        = WB'($urandom);
            carry_in  = 1'($urandom);
            sub       = 1'($urandom);
            out_ready = !(c >= 3 && c < 6);
            #1;
            if (c >= 3 && c < 6) begin
                checks++;
                if (a_in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_stall_ready: cycle %0d got in_ready=%b expected 0", c, a_in_ready);
                end
                if (c > 3) begin
                    checks++;
                    if ({a_out_valid, a_ovf, a_cout, a_z} !== held) begin
                        errors++;
                        $display("FAIL b2b_stall_hold: cycle %0d got %h expected %h", c,
                                 {a_out_valid, a_ovf, a_cout, a_z}, held);
                    end
                end
                held = {a_out_valid, a_ovf, a_cout, a_z};
            end
            if (in_valid && a_in_ready) begin
                qa.push_back(model(32'(xs), 32'(ys), carry_in, sub, WA));
                sent++;
            end
            if (a_out_valid && out_ready) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: got unexpected result z=%h expected none", a_z);
                end else begin
                    e = qa.pop_front();
                    if ({a_ovf, a_cout, a_z} !== {e[33], e[32], e[7:0]}) begin
                        errors++;
                        $display("FAIL b2b_result: beat %0d got ovf/cout/z=%b/%b/%h expected %b/%b/%h",
                                 got, a_ovf, a_cout, a_z, e[33], e[32], e[7:0]);
                    end
                end
                got++;
            end
            @(negedge clock);
        end
        in_valid = 1'b0;
        checks++;
        if (got != 6) begin
            errors++;
            $display("FAIL b2b_count: got %0d results expected 6", got);
        end
    endtask

    task automatic test_reset_flush;
        xs        = 13'h011;
        ys        = 13'h022;
        carry_in  = 1'b0;
        sub       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        xs        = 13'h033;
        out_ready = 1'b0;
        @(negedge clock);
        checks++;
        if (a_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_inflight: got out_valid=%b expected 1", a_out_valid);
        end
        reset    = 1'b1;
        xs       = 13'h044;
        @(negedge clock);
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid: got a/b out_valid=%b/%b expected 0/0", a_out_valid, b_out_valid);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            checks++;
            if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_ghost: cycle %0d got a/b out_valid=%b/%b expected 0/0",
                         c, a_out_valid, b_out_valid);
            end
        end
    endtask

    task automatic test_sweep;
        localparam int N = 2500;
        logic        a_stall, b_stall;
        logic [9:0]  a_prev;
        logic [14:0] b_prev;
        logic [33:0] e;
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        qa.delete();
        qb.delete();
        a_stall = 1'b0;
        b_stall = 1'b0;
        a_prev  = '0;
        b_prev  = '0;
        for (int c = 0; c < N + 30; c++) begin
            if (c < N) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 9) < 7);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            xs       = WB'($urandom);
            ys       = WB'($urandom);
            carry_in = 1'($urandom);
            sub      = 1'($urandom);
            #1;
            checks++;
            if (a_in_ready !== (!a_out_valid || out_ready) || b_in_ready !== (!b_out_valid || out_ready)) begin
                errors++;
                $display("FAIL sweep_ready: cycle %0d got a/b in_ready=%b/%b", c, a_in_ready, b_in_ready);
            end
            if (a_stall) begin
                checks++;
                if (a_out_valid !== 1'b1 || {a_ovf, a_cout, a_z} !== a_prev) begin
                    errors++;
                    $display("FAIL sweep_hold_a: cycle %0d got %b/%h expected 1/%h", c, a_out_valid,
                             {a_ovf, a_cout, a_z}, a_prev);
                end
            end
            if (b_stall) begin
                checks++;
                if (b_out_valid !== 1'b1 || {b_ovf, b_cout, b_z} !== b_prev) begin
                    errors++;
                    $display("FAIL sweep_hold_b: cycle %0d got %b/%h expected 1/%h", c, b_out_valid,
                             {b_ovf, b_cout, b_z}, b_prev);
                end
            end
            if (in_valid && a_in_ready) qa.push_back(model(32'(xs), 32'(ys), carry_in, sub, WA));
            if (in_valid && b_in_ready) qb.push_back(model(32'(xs), 32'(ys), carry_in, sub, WB));
            if (a_out_valid && out_ready) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL sweep_extra_a: cycle %0d got z=%h expected none", c, a_z);
                end else begin
                    e = qa.pop_front();
                    if ({a_ovf, a_cout, a_z} !== {e[33], e[32], e[WA-1:0]}) begin
                        errors++;
                        $display("FAIL sweep_a: cycle %0d got ovf/cout/z=%b/%b/%h expected %b/%b/%h",
                                 c, a_ovf, a_cout, a_z, e[33], e[32], e[WA-1:0]);
                    end
                end
            end
            if (b_out_valid && out_ready) begin
                checks++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL sweep_extra_b: cycle %0d got z=%h expected none", c, b_z);
                end else begin
                    e = qb.pop_front();
                    if ({b_ovf, b_cout, b_z} !== {e[33], e[32], e[WB-1:0]}) begin
                        errors++;
                        $display("FAIL sweep_b: cycle %0d got ovf/cout/z=%b/%b/%h expected %b/%b/%h",
                                 c, b_ovf, b_cout, b_z, e[33], e[32], e[WB-1:0]);
                    end
                end
            end
            a_stall = a_out_valid && !out_ready;
            b_stall = b_out_valid && !out_ready;
            a_prev  = {a_ovf, a_cout, a_z};
            b_prev  = {b_ovf, b_cout, b_z};
            @(negedge clock);
        end
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL sweep_drain: got %0d/%0d results outstanding expected 0/0", qa.size(), qb.size());
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        carry_in  = 1'b0;
        sub       = 1'b0;
        xs        = '0;
        ys        = '0;
        test_reset();
        test_add();
        test_overflow();
        test_sub();
        test_back_to_back();
        test_reset_flush();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
